// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and the InvShiftRows helper
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef logic [7:0] aes_byte_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_sb_state_e;
  localparam int AES_NB = 4;
  // Row r rotates right by r: out[r][c] = s[r][(c-r) mod 4], bytes column-major
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t t;
    t = '0;
    for (int c = 0; c < AES_NB; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return t;
  endfunction
endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational AES inverse S-box lookup
module inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t x,
  output aes_byte_t y
);
  always_comb begin
    y = 8'h00;
    case (x)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
  end
endmodule

// File: rtl/aes_inv_subbytes_engine.sv
// aes_inv_subbytes_engine: column-serial AES InvSubBytes, 4-cycle latency, valid/ready handshake.
// Define AES_INV_SHIFTROWS_EN to also apply InvShiftRows on the result.
module aes_inv_subbytes_engine
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);
  inv_sb_state_e state;
  logic [1:0] col;
  aes_state_t work, work_next, result;
  logic [31:0] col_in, col_out;
  assign col_in = work[127-32*col -: 32];
  for (genvar g = 0; g < AES_NB; g++) begin : g_sbox
    inv_sbox u_sbox (.x(col_in[31-8*g -: 8]), .y(col_out[31-8*g -: 8]));
  end
  always_comb begin
    work_next = work;
    work_next[127-32*col -: 32] = col_out;
  end
`ifdef AES_INV_SHIFTROWS_EN
  assign result = inv_shift_rows(work_next);
`else
  assign result = work_next;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= 2'd0;
      work <= '0;
      out_state <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          state <= BUSY;
          work <= in_state;
          col <= 2'd0;
          in_ready <= 1'b0;
          busy <= 1'b1;
        end
        BUSY: begin
          work <= work_next;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
            out_state <= result;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_subbytes_engine.sv
// tb_aes_inv_subbytes_engine: directed self-checking bench for the inverse SubBytes engine
module tb_aes_inv_subbytes_engine;
  import aes_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  aes_state_t in_state = '0, out_state;
  aes_byte_t sb_in = '0, sb_out;
  int n_checks = 0, n_fail = 0;
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  aes_inv_subbytes_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );
  inv_sbox u_sb (.x(sb_in), .y(sb_out));
  always #5 clk = ~clk;
  function automatic aes_byte_t fwd(input int x);
    logic [2047:0] t;
    t = FWD;
    return t[2047-8*x -: 8];
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input aes_state_t s, input aes_state_t exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_state = s;
    tick();
    in_valid = 1'b0;
    in_state = '0;
    check({tag, "_busy"}, 128'(busy), 128'd1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_latency"}, 128'(n), 128'd4);
    check({tag, "_out"}, out_state, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_back_idle"}, 128'(in_ready), 128'd1);
  endtask
  aes_state_t v3_in = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_INV_SHIFTROWS_EN
  aes_state_t v3_exp = 128'h52f3a338_3009d79e_bf366afb_8140a5d5;
`else
  aes_state_t v3_exp = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;
`endif
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic seen;
    repeat (2) tick();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    rst = 1'b0;
    tick();
    run("v1", {16{8'h63}}, 128'h0);
    run("v2", 128'h0, {16{8'h52}});
    run("v3", v3_in, v3_exp);
    // V4: stall in DONE while a second state is offered
    in_valid = 1'b1;
    in_state = v3_in;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("v4_latency", 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_state = (i == 3) ? {16{8'hff}} : '0;
      tick();
      check("v4_hold_out", out_state, v3_exp);
      check("v4_hold_valid", 128'(out_valid), 128'd1);
      check("v4_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("v4_drop_valid", 128'(out_valid), 128'd0);
    check("v4_idle", 128'(in_ready), 128'd1);
    tick();
    check("v4_not_accepted", 128'(busy), 128'd0);
    // V5: abort mid-operation at col=2
    in_valid = 1'b1;
    in_state = {16{8'h63}};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("v5_in_ready", 128'(in_ready), 128'd1);
    check("v5_out_valid", 128'(out_valid), 128'd0);
    check("v5_busy", 128'(busy), 128'd0);
    check("v5_out_state", out_state, 128'd0);
    seen = 1'b0;
    repeat (8) begin tick(); seen |= out_valid; end
    check("v5_no_valid", 128'(seen), 128'd0);
    run("v5_v1", {16{8'h63}}, 128'h0);
    // V6: forward then inverse S-box must be the identity
    for (int x = 0; x < 256; x++) begin
      sb_in = fwd(x);
      #1;
      check("v6_roundtrip", 128'(sb_out), 128'(x));
    end
    sb_in = 8'h01;
    #1;
    check("v6_inv_01", 128'(sb_out), 128'h09);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
